// File: rtl/count_seq_monitor_pkg.sv
// Shared definitions for the up/down mode counter and its sequence monitor.
// Holds the monitor FSM encoding and the counter mode constants.
package count_seq_monitor_pkg;

  typedef enum logic [1:0] {
    StSync  = 2'd0,
    StTrack = 2'd1,
    StFault = 2'd2
  } mon_state_e;

  localparam logic MODE_UP = 1'b0;
  localparam logic MODE_DN = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts inc pulses, holds at all-ones, clr wins over inc.
module sat_counter #(
  parameter int unsigned ERRW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inc,
  input  logic            clr,
  output logic [ERRW-1:0] value
);

  localparam logic [ERRW-1:0] ValMax = {ERRW{1'b1}};
  localparam logic [ERRW-1:0] ValOne = ERRW'(1);

  logic [ERRW-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (inc && (value_q != ValMax)) begin
      value_d = value_q + ValOne;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/count_seq_monitor.sv
// Checks an up/down mode counter against its own previous sample, flags
// mismatches and wrap events, and keeps a saturating mismatch tally.
module count_seq_monitor
  import count_seq_monitor_pkg::*;
#(
  parameter int unsigned W       = 3,
  parameter int unsigned ERRW    = 8,
  parameter int unsigned MAX_ERR = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ctr_reset,
  input  logic            mode,
  input  logic [W-1:0]    count,
  input  logic            clr,
  output logic            locked,
  output logic            err,
  output logic            wrap_up,
  output logic            wrap_dn,
  output logic            fault,
  output logic [ERRW-1:0] err_count
);

  localparam logic [W-1:0] CountMax  = {W{1'b1}};
  localparam logic [W-1:0] CountOne  = W'(1);
  localparam logic [2:0]   ConsecOne = 3'd1;
  localparam logic [2:0]   MaxErr    = 3'(MAX_ERR);

  mon_state_e state_q, state_d;

  logic [W-1:0] prev_count_q;
  logic         prev_mode_q;
  logic [2:0]   consec_q, consec_d;
  logic         err_q, err_d;
  logic         wrap_up_q, wrap_up_d;
  logic         wrap_dn_q, wrap_dn_d;

  logic [W-1:0] exp_count;
  logic         check;
  logic         mismatch;

  // Prediction uses the mode captured alongside the previous count, matching
  // the edge on which the counter itself stepped.
  always_comb begin
    exp_count = (prev_mode_q == MODE_DN) ? (prev_count_q - CountOne)
                                         : (prev_count_q + CountOne);
    check     = (state_q == StTrack) && !ctr_reset;
    mismatch  = check && (count != exp_count);
  end

  always_comb begin
    state_d   = state_q;
    consec_d  = consec_q;
    err_d     = mismatch;
    wrap_up_d = 1'b0;
    wrap_dn_d = 1'b0;

    if (check) begin
      if (mismatch) begin
        consec_d = consec_q + ConsecOne;
      end else begin
        consec_d  = '0;
        wrap_up_d = (prev_mode_q == MODE_UP) && (prev_count_q == CountMax);
        wrap_dn_d = (prev_mode_q == MODE_DN) && (prev_count_q == '0);
      end
    end else begin
      consec_d = '0;
    end

    case (state_q)
      StSync: begin
        state_d = StTrack;
      end
      StTrack: begin
        if (mismatch && !clr && (consec_d >= MaxErr)) begin
          state_d = StFault;
        end
      end
      StFault: begin
        if (clr) begin
          state_d = StSync;
        end
      end
      default: begin
        state_d = StSync;
      end
    endcase

    // A clear restarts the run of mismatches; it overrides a FAULT entry.
    if (clr) begin
      consec_d = '0;
    end

    // The counter is being cleared, so nothing it shows can be predicted.
    if (ctr_reset) begin
      state_d = StSync;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StSync;
      prev_count_q <= '0;
      prev_mode_q  <= MODE_UP;
      consec_q     <= '0;
      err_q        <= 1'b0;
      wrap_up_q    <= 1'b0;
      wrap_dn_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_count_q <= count;
      prev_mode_q  <= mode;
      consec_q     <= consec_d;
      err_q        <= err_d;
      wrap_up_q    <= wrap_up_d;
      wrap_dn_q    <= wrap_dn_d;
    end
  end

  sat_counter #(
    .ERRW (ERRW)
  ) u_err_count (
    .clk   (clk),
    .rst_n (reset),
    .inc   (mismatch),
    .clr   (clr),
    .value (err_count)
  );

  assign locked  = (state_q == StTrack);
  assign fault   = (state_q == StFault);
  assign err     = err_q;
  assign wrap_up = wrap_up_q;
  assign wrap_dn = wrap_dn_q;

endmodule
